minibyte_bus_ctrl: RTL

MINIBYTE_BUS_CTRL -- requirements
Module: minibyte_bus_ctrl

---
 rtl/minibyte_bus_pkg.sv | 27 ++
 rtl/minibyte_bus_ctrl_ext_bus_seq.sv | 73 +++++++
 rtl/minibyte_bus_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/minibyte_bus_pkg.sv
// Shared types and constants for the minibyte bus controller: FSM states, decode regions,
// default IO port address, default external timeout and the ROM window limit.
package minibyte_bus_pkg;

  localparam logic [7:0] IO_ADDR_DEFAULT     = 8'h40;
  localparam logic [7:0] ROM_LIMIT           = 8'h20;
  localparam int         EXT_TIMEOUT_DEFAULT = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOCAL,
    ST_ALE,
    ST_DATA,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    REGION_ROM,
    REGION_IO,
    REGION_EXT
  } region_e;

  function automatic logic is_rom_addr(input logic [7:0] addr);
    return addr < ROM_LIMIT;
  endfunction

endpackage

// File: rtl/minibyte_bus_ctrl_ext_bus_seq.sv
// External bus sequencer: drives ALE/OE/WE and the multiplexed bus in the ALE and DATA
// phases, captures read data, and forces completion after EXT_TIMEOUT consecutive waits.
module ext_bus_seq
  import minibyte_bus_pkg::*;
#(
  parameter int EXT_TIMEOUT = EXT_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  state_e     i_state,
  input  logic       i_is_wr,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wdata,
  input  logic       i_ext_wait,
  input  logic [7:0] i_ext_bus_in,
  output logic [7:0] o_ext_bus_out,
  output logic       o_ext_ale,
  output logic       o_ext_oe,
  output logic       o_ext_we,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic       o_err
);

  localparam int CW = $clog2(EXT_TIMEOUT + 1);

  logic [CW-1:0] r_wait_cnt;
  logic [7:0]    r_rdata;
  logic          r_err;
  logic          w_in_data;
  logic          w_timeout;

  assign w_in_data = (i_state == ST_DATA);
  // The last permitted wait cycle completes the access instead of counting further.
  assign w_timeout = w_in_data && i_ext_wait && (r_wait_cnt == CW'(EXT_TIMEOUT - 1));
  assign o_done    = w_in_data && (!i_ext_wait || w_timeout);
  assign o_rdata   = r_rdata;
  assign o_err     = r_err;

  always_comb begin
    o_ext_ale     = (i_state == ST_ALE);
    o_ext_oe      = w_in_data && !i_is_wr;
    o_ext_we      = w_in_data && i_is_wr;
    o_ext_bus_out = 8'h00;
    if (o_ext_ale) begin
      o_ext_bus_out = i_addr;
    end else if (o_ext_we) begin
      o_ext_bus_out = i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
      r_rdata    <= 8'h00;
      r_err      <= 1'b0;
    end else if (i_state == ST_ALE) begin
      r_wait_cnt <= '0;
      r_rdata    <= 8'h00;
      r_err      <= 1'b0;
    end else if (w_in_data) begin
      if (!i_ext_wait) begin
        r_rdata <= i_is_wr ? 8'h00 : i_ext_bus_in;
      end else if (w_timeout) begin
        r_rdata <= 8'hFF;
        r_err   <= 1'b1;
      end else begin
        r_wait_cnt <= r_wait_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/minibyte_bus_ctrl.sv
// Minibyte bus controller: routes CPU byte accesses to the ROM, the IO port register or the
// multiplexed external bus. Define MINIBYTE_DEMO_ROM_EN to map 8'h00-8'h1F onto the ROM.
module minibyte_bus_ctrl
  import minibyte_bus_pkg::*;
#(
  parameter logic [7:0] IO_ADDR     = IO_ADDR_DEFAULT,
  parameter int         EXT_TIMEOUT = EXT_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  input  logic       cpu_rd,
  input  logic       cpu_wr,
  output logic [7:0] cpu_rdata,
  output logic       cpu_ready,
  output logic       cpu_err,
  output logic [4:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic [7:0] ext_bus_out,
  input  logic [7:0] ext_bus_in,
  output logic       ext_ale,
  output logic       ext_oe,
  output logic       ext_we,
  input  logic       ext_wait,
  output logic [7:0] io_out
);

  state_e     r_state;
  state_e     w_state_nxt;
  region_e    w_region;
  region_e    r_region;
  logic       r_is_wr;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_io;
  logic       w_accept;
  logic       w_ext_done;
  logic       w_ext_err;
  logic [7:0] w_ext_rdata;
  logic [7:0] w_rom_rdata;

  assign w_accept = (r_state == ST_IDLE) && (cpu_rd || cpu_wr);
  assign io_out   = r_io;

  // NOTE: every signal driven in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    w_region = REGION_EXT;
    if (cpu_addr == IO_ADDR) begin
      w_region = REGION_IO;
    end
`ifdef MINIBYTE_DEMO_ROM_EN
    if (is_rom_addr(cpu_addr)) begin
      w_region = REGION_ROM;
    end
`endif
  end

`ifdef MINIBYTE_DEMO_ROM_EN
  assign rom_addr    = cpu_addr[4:0];
  assign w_rom_rdata = rom_data;
`else
  logic w_rom_unused;
  assign rom_addr     = 5'h00;
  assign w_rom_rdata  = 8'h00;
  assign w_rom_unused = ^rom_data;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = (w_region == REGION_EXT) ? ST_ALE : ST_LOCAL;
      ST_LOCAL: w_state_nxt = ST_IDLE;
      ST_ALE:   w_state_nxt = ST_DATA;
      ST_DATA:  if (w_ext_done) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // A write wins over a simultaneous read; an abandoned LOCAL cycle never reaches the IO load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_is_wr  <= 1'b0;
      r_addr   <= 8'h00;
      r_wdata  <= 8'h00;
      r_region <= REGION_EXT;
      r_io     <= 8'h00;
    end else begin
      if (w_accept) begin
        r_is_wr  <= cpu_wr;
        r_addr   <= cpu_addr;
        r_wdata  <= cpu_wdata;
        r_region <= w_region;
      end
      if ((r_state == ST_LOCAL) && (r_region == REGION_IO) && r_is_wr) begin
        r_io <= r_wdata;
      end
    end
  end

  always_comb begin
    cpu_ready = 1'b0;
    cpu_err   = 1'b0;
    cpu_rdata = 8'h00;
    case (r_state)
      ST_LOCAL: begin
        cpu_ready = 1'b1;
        if (!r_is_wr) begin
          cpu_rdata = (r_region == REGION_ROM) ? w_rom_rdata : r_io;
        end
      end
      ST_DONE: begin
        cpu_ready = 1'b1;
        cpu_err   = w_ext_err;
        cpu_rdata = w_ext_rdata;
      end
      default: ;
    endcase
  end

  ext_bus_seq #(
    .EXT_TIMEOUT (EXT_TIMEOUT)
  ) u_ext_bus_seq (
    .clk           (clk),
    .rst           (rst),
    .i_state       (r_state),
    .i_is_wr       (r_is_wr),
    .i_addr        (r_addr),
    .i_wdata       (r_wdata),
    .i_ext_wait    (ext_wait),
    .i_ext_bus_in  (ext_bus_in),
    .o_ext_bus_out (ext_bus_out),
    .o_ext_ale     (ext_ale),
    .o_ext_oe      (ext_oe),
    .o_ext_we      (ext_we),
    .o_done        (w_ext_done),
    .o_rdata       (w_ext_rdata),
    .o_err         (w_ext_err)
  );

endmodule
